// File: rtl/extended_hamming_pkg.sv
// Shared types and width helpers for the extended Hamming (SECDED) stream encoder.
package extended_hamming_pkg;

  typedef enum logic [1:0] {
    INJ_NONE,
    INJ_SINGLE,
    INJ_DOUBLE
  } inj_kind_t;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } buf_state_t;

  // Hamming bits r with 2^r >= dw + r + 1, plus one overall parity bit.
  function automatic int get_extended_hamming_parity_width(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r + 1;
  endfunction

  // Largest data width a given code width protects: 2^(pw-1) - (pw-1) - 1.
  function automatic int get_extended_hamming_data_width(input int pw);
    return (1 << (pw - 1)) - pw;
  endfunction

  function automatic logic [1:0] inj_mask(input inj_kind_t k);
    logic [1:0] m;
    m = 2'b00;
    unique case (k)
      INJ_SINGLE: m = 2'b01;
      INJ_DOUBLE: m = 2'b11;
      default:    m = 2'b00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/extended_hamming_encoder.sv
// Combinational extended Hamming encoder: code = {overall parity, hamming bits}.
// Data is zero-padded to the full width the code covers, matching the checker.
module extended_hamming_encoder
  import extended_hamming_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  localparam int PARITY_WIDTH = get_extended_hamming_parity_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [PARITY_WIDTH-1:0] code_o
);

  localparam int HP   = PARITY_WIDTH - 1;
  localparam int PADW = get_extended_hamming_data_width(PARITY_WIDTH);

  // Data bit k sits at the k-th non-power-of-two codeword position;
  // hamming bit i covers every position with bit i set.
  function automatic logic [PADW-1:0] cover_mask(input int i);
    logic [PADW-1:0] m;
    int p;
    m = '0;
    p = 2;
    for (int k = 0; k < PADW; k++) begin
      p++;
      while ((p & (p - 1)) == 0) p++;
      m[k] = ((p >> i) & 1) != 0;
    end
    return m;
  endfunction

  logic [PADW-1:0] pad;
  logic [HP-1:0]   hp;

  assign pad = PADW'(data_i);

  for (genvar i = 0; i < HP; i++) begin : g_hp
    localparam logic [PADW-1:0] M = cover_mask(i);
    assign hp[i] = ^(pad & M);
  end

  assign code_o = {(^pad) ^ (^hp), hp};

endmodule

// File: rtl/extended_hamming_stream_encoder.sv
// Streaming SECDED encoder with a registered 2-entry skid buffer and
// one-shot single/double error injection on the outgoing data.
module extended_hamming_stream_encoder
  import extended_hamming_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  localparam int PARITY_WIDTH = get_extended_hamming_parity_width(DATA_WIDTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [PARITY_WIDTH-1:0] out_code,
  input  logic                    inject_single,
  input  logic                    inject_double,
  output logic                    injection_pending
);

  buf_state_t              state_q;
  logic [DATA_WIDTH-1:0]   main_data_q, skid_data_q;
  logic [PARITY_WIDTH-1:0] main_code_q, skid_code_q;
  logic                    in_ready_q, out_valid_q;
  logic                    arm_s_q, arm_d_q, pend_q;

  logic                    in_xfer, out_xfer;
  logic                    arm_s_d, arm_d_d;
  inj_kind_t               kind;
  logic [DATA_WIDTH-1:0]   word_data;
  logic [PARITY_WIDTH-1:0] word_code;

  extended_hamming_encoder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_enc (
    .data_i(in_data),
    .code_o(word_code)
  );

  // Double wins over single; an accepted word consumes every armed flag.
  always_comb begin
    in_xfer  = in_valid & in_ready_q;
    out_xfer = out_valid_q & out_ready;
    arm_s_d  = arm_s_q | inject_single;
    arm_d_d  = arm_d_q | inject_double;
    kind     = INJ_NONE;
    priority case (1'b1)
      arm_d_d: kind = INJ_DOUBLE;
      arm_s_d: kind = INJ_SINGLE;
      default: kind = INJ_NONE;
    endcase
    word_data = in_data ^ DATA_WIDTH'(inj_mask(kind));
    if (in_xfer) begin
      arm_s_d = 1'b0;
      arm_d_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= BUF_EMPTY;
      main_data_q <= '0;
      main_code_q <= '0;
      skid_data_q <= '0;
      skid_code_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      arm_s_q     <= 1'b0;
      arm_d_q     <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      arm_s_q <= arm_s_d;
      arm_d_q <= arm_d_d;
      pend_q  <= arm_s_d | arm_d_d;
      unique case (state_q)
        BUF_EMPTY: begin
          if (in_xfer) begin
            main_data_q <= word_data;
            main_code_q <= word_code;
            out_valid_q <= 1'b1;
            state_q     <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          unique case ({in_xfer, out_xfer})
            2'b10: begin
              skid_data_q <= word_data;
              skid_code_q <= word_code;
              in_ready_q  <= 1'b0;
              state_q     <= BUF_FULL;
            end
            2'b01: begin
              out_valid_q <= 1'b0;
              state_q     <= BUF_EMPTY;
            end
            2'b11: begin
              main_data_q <= word_data;
              main_code_q <= word_code;
            end
            default: ;
          endcase
        end
        BUF_FULL: begin
          if (out_xfer) begin
            main_data_q <= skid_data_q;
            main_code_q <= skid_code_q;
            in_ready_q  <= 1'b1;
            state_q     <= BUF_ONE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= BUF_EMPTY;
        end
      endcase
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign out_data          = main_data_q;
  assign out_code          = main_code_q;
  assign injection_pending = pend_q;

endmodule

// File: tb/tb_extended_hamming_stream_encoder.sv
// Scoreboard bench for extended_hamming_stream_encoder: directed cases plus
// randomized traffic against a positional-XOR SECDED reference model.
module tb_extended_hamming_stream_encoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [4:0] out_code;
  logic       inject_single = 1'b0;
  logic       inject_double = 1'b0;
  logic       injection_pending;

  extended_hamming_stream_encoder #(
    .DATA_WIDTH(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_code(out_code),
    .inject_single(inject_single),
    .inject_double(inject_double),
    .injection_pending(injection_pending)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic [4:0] code;
    int         cls;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   arm_s = 0;
  bit   arm_d = 0;

  always @(posedge clock) cyc++;

  // Syndrome = XOR of the codeword positions of all set data bits.
  function automatic logic [3:0] ref_syn(input logic [7:0] d);
    logic [3:0] s;
    int pos;
    s = 4'h0;
    pos = 2;
    for (int k = 0; k < 8; k++) begin
      pos++;
      while ((pos & (pos - 1)) == 0) pos++;
      if (d[k]) s = s ^ 4'(pos);
    end
    return s;
  endfunction

  function automatic logic [4:0] ref_code(input logic [7:0] d);
    logic [3:0] s;
    s = ref_syn(d);
    return {(^d) ^ (^s), s};
  endfunction

  // 0 = clean, 1 = correctable, 2 = uncorrectable
  function automatic int chk_class(input logic [7:0] d, input logic [4:0] c);
    logic [3:0] syn;
    logic ov;
    syn = ref_syn(d) ^ c[3:0];
    ov  = (^d) ^ (^c);
    if (ov) return 1;
    if (syn != 4'h0) return 2;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    bit s, d, room;
    logic [1:0] m;
    int cls;
    if (reset) begin
      q.delete();
      arm_s = 0;
      arm_d = 0;
    end else begin
      room = q.size() < 2;
      check("in_ready", in_ready, room);
      check("out_valid", out_valid, q.size() != 0);
      check("pending", injection_pending, arm_s | arm_d);
      if (out_valid && q.size() != 0) begin
        check("out_data", out_data, q[0].data);
        check("out_code", out_code, q[0].code);
        check("checker", chk_class(out_data, out_code), q[0].cls);
        if (out_ready) void'(q.pop_front());
      end
      s = arm_s | inject_single;
      d = arm_d | inject_double;
      if (in_valid && room) begin
        m   = d ? 2'b11 : (s ? 2'b01 : 2'b00);
        cls = d ? 2 : (s ? 1 : 0);
        q.push_back('{in_data ^ {6'b0, m}, ref_code(in_data), cls});
        arm_s = 0;
        arm_d = 0;
      end else begin
        arm_s = s;
        arm_d = d;
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 data %0h", d);
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    #1 check("drain", q.size(), 0);
  endtask

  task automatic pulse(input logic s, input logic d);
    inject_single = s;
    inject_double = d;
    @(posedge clock);
    #1;
    inject_single = 1'b0;
    inject_double = 1'b0;
  endtask

  initial begin
    int t0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_pending", injection_pending, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_code", out_code, 0);
    reset = 1'b0;

    out_ready = 1'b1;
    send(8'h00);
    check("latency", out_valid, 1);
    wait_drain();

    t0 = cyc;
    for (int i = 0; i < 256; i++) send(8'(i));
    check("throughput", cyc - t0, 256);
    wait_drain();

    out_ready = 1'b0;
    send(8'hA5);
    send(8'h5A);
    fork
      send(8'h3C);
      begin
        repeat (3) @(posedge clock);
        #2;
        check("stall_ready", in_ready, 0);
        check("stall_hold", out_data, 8'hA5);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    pulse(1'b1, 1'b0);
    check("pend_armed", injection_pending, 1);
    send(8'h00);
    check("pend_clear", injection_pending, 0);
    send(8'h00);
    wait_drain();

    pulse(1'b1, 1'b1);
    check("pend_both", injection_pending, 1);
    send(8'hFF);
    check("pend_both_clr", injection_pending, 0);
    wait_drain();

    out_ready = 1'b0;
    send(8'h11);
    send(8'h22);
    pulse(1'b1, 1'b0);
    check("full_ready", in_ready, 0);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_pend", injection_pending, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    send(8'h77);
    wait_drain();

    repeat (3000) begin
      @(posedge clock);
      #1;
      in_valid      = ($urandom % 4) != 0;
      in_data       = 8'($urandom);
      out_ready     = ($urandom % 3) != 0;
      inject_single = ($urandom % 16) == 0;
      inject_double = ($urandom % 23) == 0;
    end
    @(posedge clock);
    #1;
    in_valid      = 1'b0;
    inject_single = 1'b0;
    inject_double = 1'b0;
    out_ready     = 1'b1;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
